// File: rtl/dgiota_freq_meter.sv
// Gated rising-edge counter for a digitized analog tap: counts synchronized
// edges over 2^GATE_LOG2 clocks and presents the saturated result byte-wise.
module dgiota_freq_meter #(
    parameter int unsigned GATE_LOG2 = 16,
    parameter int unsigned CNT_W     = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sig_in,
    input  logic       start,
    input  logic       continuous,
    input  logic [1:0] byte_sel,
    output logic [7:0] count_out,
    output logic       busy,
    output logic       done,
    output logic       overflow
);

    typedef enum logic {
        IDLE = 1'b0,
        GATE = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, sync2_q, prev_q;
    logic [GATE_LOG2-1:0] timer_q, timer_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 sticky_q, sticky_d;
    logic [CNT_W-1:0]     result_q, result_d;
    logic                 ovf_q, ovf_d;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;

    logic                 edge_w;
    logic                 sat_w;
    logic [CNT_W-1:0]     cnt_inc_w;
    logic [23:0]          result_ext;

    assign edge_w = sync2_q & ~prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            prev_q   <= 1'b0;
            timer_q  <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= sig_in;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            timer_q  <= timer_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end

    // Counter holds at all-ones once full; the edge that would wrap it flags saturation.
    assign sat_w     = edge_w && (cnt_q == '1);
    assign cnt_inc_w = sat_w ? cnt_q : cnt_q + CNT_W'(edge_w);

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d  = '0;
                cnt_d    = '0;
                sticky_d = 1'b0;
                if (start || continuous) state_d = GATE;
            end
            GATE: begin
                timer_d  = timer_q + 1'b1;
                cnt_d    = cnt_inc_w;
                sticky_d = sticky_q | sat_w;
                // Last gate cycle: the edge seen now is folded into the latched result.
                if (timer_q == '1) begin
                    result_d = cnt_inc_w;
                    ovf_d    = sticky_q | sat_w;
                    valid_d  = 1'b1;
                    done_d   = 1'b1;
                    timer_d  = '0;
                    cnt_d    = '0;
                    sticky_d = 1'b0;
                    if (!continuous) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        result_ext             = '0;
        result_ext[CNT_W-1:0]  = result_q;
    end

    always_comb begin
        case (byte_sel)
            2'd0:    count_out = result_ext[7:0];
            2'd1:    count_out = result_ext[15:8];
            2'd2:    count_out = result_ext[23:16];
            default: count_out = {ovf_q, valid_q, busy, 5'b0};
        endcase
    end

    assign busy     = (state_q == GATE);
    assign done     = done_q;
    assign overflow = ovf_q;

endmodule

// File: doc/dgiota_freq_meter.md
# dgiota_freq_meter

Gated edge counter downstream of the analog test macro in `tt_um_test_13`. It takes one digitized analog output, such as a ring-oscillator or comparator tap routed back onto a digital input, and synchronizes it. It counts rising edges over a fixed window of 2^GATE_LOG2 clocks, latches the count, and presents it byte-wise on the dedicated outputs for readout.

## Interface
- GATE_LOG2, default 16: gate window length is 2^GATE_LOG2 clocks. Legal range 4..20.
- CNT_W, default 24: counter/result width. Legal range 1..24. Result bits above CNT_W read as 0.

- clk  input  1  system clock
- rst_n  input  1  synchronous, active-low reset
- sig_in  input  1  asynchronous signal from the analog test structure
- start  input  1  request one measurement; sampled only in IDLE
- continuous  input  1  when high, gates run back-to-back with no dead cycles
- byte_sel  input  2  readout select: 0=result[7:0], 1=result[15:8], 2=result[23:16], 3=status {overflow, valid, busy, 5'b0}
- count_out  output  8  selected readout byte (combinational mux of registered values)
- busy  output  1  high while in GATE
- done  output  1  one-cycle pulse when a new result is latched
- overflow  output  1  saturation flag of the latched result

## Operation
- Input path: 2-FF synchronizer on sig_in, then a third flop for edge detect. edge = sync & ~prev.
- FSM has two states.
  - IDLE: counter and timer are held at 0. If start or continuous is high, go to GATE.
  - GATE: timer increments each cycle, and each edge pulse increments the counter.
  - On the final GATE cycle (timer = 2^GATE_LOG2−1):
    - result <= counter + edge, saturated.
    - overflow <= sticky_ovf | (saturation this cycle).
    - valid <= 1.
    - done pulses next cycle.
    - If continuous is high, the state stays GATE with counter, timer and sticky_ovf cleared. Otherwise go to IDLE.
- Saturation: the counter stops at 2^CNT_W−1 and sets sticky_ovf. sticky_ovf clears at the start of each gate.
- Each latch overwrites result, overflow and valid. They hold until the next latch or reset.
- start while busy is ignored, not queued.
- continuous dropping mid-gate: the current gate completes and latches, then the FSM returns to IDLE.
- Every 0→1 transition of the synchronized signal is counted. The sig_in high and low phases must each be ≥1 clock period to register.

## Timing
- Reset: all flops cleared.
  - FSM in IDLE.
  - result=0, overflow=0, valid=0, busy=0, done=0.
  - count_out=0 for byte_sel 0..2.
  - Synchronizer flops = 0.
- start high in IDLE at edge t:
  - GATE during cycles t+1 … t+2^GATE_LOG2, with busy high over exactly these cycles.
  - result is valid and done is high in cycle t+2^GATE_LOG2+1.
- Latency from sig_in rising to edge pulse is 3 clocks. An edge is counted iff its pulse falls in a GATE cycle.
- Continuous mode: gate n+1 begins in the cycle done pulses for gate n.
  - busy stays high.
  - No edge pulse is lost or double-counted across the boundary.
- rst_n low mid-gate: the next cycle is IDLE with all outputs at reset values. No done is issued, and the partial count is discarded.

## Test plan
- Count a square wave (GATE_LOG2=4, CNT_W=24): sig_in is a period-4 square wave, pulse start. Required: busy high for 16 cycles, then done for one cycle; byte_sel=0 reads 0x04, byte_sel=1/2 read 0x00, byte_sel=3 reads 0x40.
- Idle input: hold sig_in constant at 1, pulse start. Required: result 0x000000, overflow 0, done after 16 GATE cycles.
- Saturation (CNT_W=3, GATE_LOG2=4): sig_in is a period-2 square wave (8 edges per gate). Required: result 7, overflow 1, byte_sel=3 reads 0xC0. A following gate with sig_in constant returns result 0 and overflow 0.
- Continuous mode: continuous=1 with a period-4 wave for 3 gates. Required:
  - busy never drops.
  - done pulses 16 cycles apart, with result 4 each time.
  - Drop continuous during gate 3: exactly one more done, then busy=0.
- start ignored while busy: a second start pulse mid-gate. Required: exactly one done and one 16-cycle gate.
- Reset mid-operation: rst_n low for one cycle at GATE cycle 8 after a prior valid result of 4. Required: next cycle busy=0, result=0, valid=0, and no done pulse follows.
